// File: rtl/vadd_a_b_example_axis_gen.sv
// vadd_a_b_example_axis_gen
// AXI4-Stream source for the vector-add datapath. A ctrl_start pulse in IDLE
// launches a packet of ctrl_xfer_size_in_beats full-width beats. Lane j of
// each beat carries base + j (modulo 2^C_ADDER_BIT_WIDTH). base starts at
// ctrl_seed and advances by LANES per accepted beat. tlast marks the final
// beat, and ctrl_done pulses once that beat has been accepted. A zero-length
// request skips straight to the done pulse.
//
// Ports:
//   m_axis_aclk             clock, rising edge
//   m_axis_aresetn          asynchronous active-low reset
//   ctrl_start              one-cycle start request (honoured only in IDLE)
//   ctrl_xfer_size_in_beats beat count, sampled with ctrl_start
//   ctrl_seed               lane-0 value of beat 0, sampled with ctrl_start
//   ctrl_busy               high while the packet is being sent
//   ctrl_done               one-cycle pulse at the end of a transfer
//   m_axis_*                AXI4-Stream master (tvalid/tready/tdata/tkeep/tlast)
module vadd_a_b_example_axis_gen #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_aresetn,
  input  logic                            ctrl_start,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_beats,
  input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_seed,
  output logic                            ctrl_busy,
  output logic                            ctrl_done,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam int LANES  = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam int KEEP_W = C_AXIS_TDATA_WIDTH / 8;

  localparam logic [C_XFER_SIZE_WIDTH-1:0] ZERO_BEATS = C_XFER_SIZE_WIDTH'(0);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] ONE_BEAT   = C_XFER_SIZE_WIDTH'(1);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] TWO_BEATS  = C_XFER_SIZE_WIDTH'(2);
  localparam logic [C_ADDER_BIT_WIDTH-1:0] BASE_STEP  = C_ADDER_BIT_WIDTH'(LANES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                           state_r, state_s;
  logic [C_XFER_SIZE_WIDTH-1:0]     remaining_r, remaining_s;
  logic [C_ADDER_BIT_WIDTH-1:0]     base_r, base_s;
  logic                             tvalid_r, tvalid_s;
  logic                             tlast_r, tlast_s;
  logic [C_AXIS_TDATA_WIDTH-1:0]    tdata_r, tdata_s;
  logic                             busy_r, busy_s;
  logic                             done_r, done_s;

  // Builds one beat: lane j = b + j, wrapping silently at the lane width.
  function automatic logic [C_AXIS_TDATA_WIDTH-1:0] lane_pattern(
    input logic [C_ADDER_BIT_WIDTH-1:0] b
  );
    logic [C_AXIS_TDATA_WIDTH-1:0] r;
    r = {C_AXIS_TDATA_WIDTH{1'b0}};
    for (int j = 0; j < LANES; j++) begin
      r[j*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] = b + C_ADDER_BIT_WIDTH'(j);
    end
    return r;
  endfunction

  // Next-state and next-output logic. Outputs are computed one cycle ahead so
  // that every port is driven straight from a flop.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    base_s      = base_r;
    tvalid_s    = tvalid_r;
    tlast_s     = tlast_r;
    tdata_s     = tdata_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_start) begin
          if (ctrl_xfer_size_in_beats != ZERO_BEATS) begin
            state_s     = ST_RUN;
            remaining_s = ctrl_xfer_size_in_beats;
            base_s      = ctrl_seed;
            tvalid_s    = 1'b1;
            tlast_s     = (ctrl_xfer_size_in_beats == ONE_BEAT);
            tdata_s     = lane_pattern(ctrl_seed);
            busy_s      = 1'b1;
          end else begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tvalid_r && m_axis_tready) begin
          if (remaining_r == ONE_BEAT) begin
            state_s  = ST_DONE;
            tvalid_s = 1'b0;
            tlast_s  = 1'b0;
            busy_s   = 1'b0;
            done_s   = 1'b1;
          end else begin
            // The beat after this one is the last when two remain now.
            remaining_s = remaining_r - ONE_BEAT;
            base_s      = base_r + BASE_STEP;
            tdata_s     = lane_pattern(base_r + BASE_STEP);
            tlast_s     = (remaining_r == TWO_BEATS);
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        done_s  = 1'b0;
      end
      default: begin
        state_s  = ST_IDLE;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; asynchronous reset aborts any packet.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_r     <= ST_IDLE;
      remaining_r <= ZERO_BEATS;
      base_r      <= {C_ADDER_BIT_WIDTH{1'b0}};
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      tdata_r     <= {C_AXIS_TDATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      base_r      <= base_s;
      tvalid_r    <= tvalid_s;
      tlast_r     <= tlast_s;
      tdata_r     <= tdata_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign ctrl_busy     = busy_r;
  assign ctrl_done     = done_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;
  assign m_axis_tdata  = tdata_r;
  // Every beat is full width.
  assign m_axis_tkeep  = {KEEP_W{1'b1}};

endmodule

// File: tb/tb_vadd_a_b_example_axis_gen.sv
// Directed self-checking bench for vadd_a_b_example_axis_gen (512/32/32).
module tb_vadd_a_b_example_axis_gen;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [31:0]  size;
  logic [31:0]  seed;
  logic         busy;
  logic         done;
  logic         tvalid;
  logic         tready;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int dones  = 0;
  int xfer_base;
  int done_base;
  logic [511:0] held;

  vadd_a_b_example_axis_gen dut (
    .m_axis_aclk             (clk),
    .m_axis_aresetn          (rst_n),
    .ctrl_start              (start),
    .ctrl_xfer_size_in_beats (size),
    .ctrl_seed               (seed),
    .ctrl_busy               (busy),
    .ctrl_done               (done),
    .m_axis_tvalid           (tvalid),
    .m_axis_tready           (tready),
    .m_axis_tdata            (tdata),
    .m_axis_tkeep            (tkeep),
    .m_axis_tlast            (tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted beats and done pulses as seen at the clock edge.
  always @(posedge clk) begin
    if (tvalid === 1'b1 && tready === 1'b1) xfers <= xfers + 1;
    if (done === 1'b1) dones <= dones + 1;
  end

  // Expected beat: lane j = b + j modulo 2^32.
  function automatic logic [511:0] exp_lanes(input logic [31:0] b);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = b + 32'(j);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; size = 32'd0; seed = 32'd0; tready = 1'b0;
    tick(); tick();
    chk("rst_tvalid", 512'(tvalid), 512'd0);
    chk("rst_tlast",  512'(tlast),  512'd0);
    chk("rst_busy",   512'(busy),   512'd0);
    chk("rst_done",   512'(done),   512'd0);
    chk("rst_tdata",  tdata,        512'd0);
    chk("rst_tkeep",  512'(tkeep),  512'(64'hFFFF_FFFF_FFFF_FFFF));
    rst_n = 1'b1;
    tick();

    // Basic run: seed 0x10, size 3, sink always ready.
    xfer_base = xfers; done_base = dones;
    start = 1'b1; size = 32'd3; seed = 32'h10; tready = 1'b1;
    tick(); start = 1'b0; size = 32'd77; seed = 32'hDEAD;
    chk("b0_tvalid", 512'(tvalid), 512'd1);
    chk("b0_busy",   512'(busy),   512'd1);
    chk("b0_tdata",  tdata, exp_lanes(32'h10));
    chk("b0_lane15", 512'(tdata[511:480]), 512'(32'h1F));
    chk("b0_tlast",  512'(tlast),  512'd0);
    tick();
    chk("b1_tdata",  tdata, exp_lanes(32'h20));
    chk("b1_tlast",  512'(tlast),  512'd0);
    tick();
    chk("b2_tdata",  tdata, exp_lanes(32'h30));
    chk("b2_tlast",  512'(tlast),  512'd1);
    chk("b2_busy",   512'(busy),   512'd1);
    tick();
    chk("b_done",    512'(done),   512'd1);
    chk("b_tvalid_off", 512'(tvalid), 512'd0);
    chk("b_busy_off", 512'(busy),  512'd0);
    tick();
    chk("b_done_pulse", 512'(done), 512'd0);
    chk("b_xfers", 512'(xfers - xfer_base), 512'd3);
    chk("b_dones", 512'(dones - done_base), 512'd1);

    // Backpressure: size 2, sink stalled for 5 cycles after tvalid rises.
    xfer_base = xfers;
    tready = 1'b0; start = 1'b1; size = 32'd2; seed = 32'h100;
    tick(); start = 1'b0;
    held = exp_lanes(32'h100);
    for (int i = 0; i < 5; i++) begin
      chk("bp_tvalid", 512'(tvalid), 512'd1);
      chk("bp_tdata",  tdata, held);
      chk("bp_tlast",  512'(tlast),  512'd0);
      if (i < 4) tick();
    end
    tready = 1'b1;
    tick();
    chk("bp_b1_tdata", tdata, exp_lanes(32'h110));
    chk("bp_b1_tlast", 512'(tlast), 512'd1);
    tick();
    chk("bp_done",  512'(done),  512'd1);
    chk("bp_tvalid_off", 512'(tvalid), 512'd0);
    chk("bp_xfers", 512'(xfers - xfer_base), 512'd2);
    tick();

    // Wrap-around of lane values at 2^32.
    start = 1'b1; size = 32'd2; seed = 32'hFFFF_FFF8;
    tick(); start = 1'b0;
    chk("w0_tdata", tdata, exp_lanes(32'hFFFF_FFF8));
    chk("w0_lane7", 512'(tdata[255:224]), 512'(32'hFFFF_FFFF));
    chk("w0_lane8", 512'(tdata[287:256]), 512'd0);
    tick();
    chk("w1_lane0",  512'(tdata[31:0]),    512'(32'h8));
    chk("w1_lane15", 512'(tdata[511:480]), 512'(32'h17));
    chk("w1_tlast",  512'(tlast), 512'd1);
    tick(); tick();

    // Zero length: no beats, done one cycle after start.
    xfer_base = xfers;
    start = 1'b1; size = 32'd0; seed = 32'h5;
    tick(); start = 1'b0;
    chk("z_done",   512'(done),   512'd1);
    chk("z_tvalid", 512'(tvalid), 512'd0);
    chk("z_busy",   512'(busy),   512'd0);
    tick();
    chk("z_done_pulse", 512'(done), 512'd0);
    chk("z_tvalid2", 512'(tvalid), 512'd0);
    chk("z_xfers", 512'(xfers - xfer_base), 512'd0);

    // Start while busy is ignored.
    xfer_base = xfers; done_base = dones;
    start = 1'b1; size = 32'd4; seed = 32'd0;
    tick(); start = 1'b0;
    tick(); start = 1'b1; size = 32'd100; seed = 32'h999;
    tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sb_xfers", 512'(xfers - xfer_base), 512'd4);
    chk("sb_dones", 512'(dones - done_base), 512'd1);
    chk("sb_idle_tvalid", 512'(tvalid), 512'd0);

    // Reset mid-transfer, then a fresh one-beat packet.
    done_base = dones;
    start = 1'b1; size = 32'd8; seed = 32'd0;
    tick(); start = 1'b0;
    tick(); tick();
    chk("rm_tvalid_pre", 512'(tvalid), 512'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_tvalid", 512'(tvalid), 512'd0);
    chk("rm_busy",   512'(busy),   512'd0);
    chk("rm_tdata",  tdata,        512'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rm_no_done", 512'(dones - done_base), 512'd0);
    xfer_base = xfers;
    start = 1'b1; size = 32'd1; seed = 32'd0;
    tick(); start = 1'b0;
    chk("rm_tdata_new", tdata, exp_lanes(32'd0));
    chk("rm_lane15", 512'(tdata[511:480]), 512'(32'hF));
    chk("rm_tlast",  512'(tlast), 512'd1);
    tick();
    chk("rm_done",   512'(done),  512'd1);
    chk("rm_xfers",  512'(xfers - xfer_base), 512'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
